vdc_regbank: RTL and testbench
==============================

# vdc_regbank

Parametrised indirect register bank for the C128 VDC (8563/8568 family), successor to the fixed 37-register file. It decodes the two-port CPU interface (address/status port and data port), holds up to NREGS 8-bit registers with per-bit implemented masks, and latches the light pen position. It forwards RAM-side register accesses (R18/19/30–33) to the RAM interface over a req/ack handshake with a one-entry pending buffer. Optionally, it double-buffers the CRTC timing registers so they commit only at frame start.

## Interface
- NREGS, 38, number of registers (38..64); selects ≥ NREGS read 8'hFF, writes ignored
- WMASK, {NREGS{8'hFF}}, flattened per-register implemented-bit mask; bit i of register r at [8r+i]
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- version  in  2  0=8563R7A, 1=8563R9, 2=8568
- bus_en  in  1  CPU bus qualifier; all bus side effects only when high
- cs, rs, we  in  1 each  chip select, register select (0=address/status, 1=data), write enable
- db_in  in  8  CPU write data
- db_out  out  8  CPU read data, registered
- lp_strobe  in  1  light pen trigger pulse
- lp_h, lp_v  in  8 each  current beam H/V position
- vsync  in  1  vertical sync status
- frame_start  in  1  one-cycle pulse at frame start
- regs_q  out  8*NREGS  effective register values, flattened
- ram_req  out  1  RAM access request, level
- ram_we  out  1  1=write, 0=read-ahead, valid with ram_req
- ram_reg  out  6  register index of request
- ram_wdata  out  8  write data of request
- ram_ack  in  1  request accepted/completed
- ram_rdata  in  8  read data, valid with ram_ack when ram_we=0
- busy  out  1  request outstanding or pending entry valid
- overflow  out  1  sticky: RAM access dropped

## Operation
- Bus write = cs&we&bus_en. With rs=0, regsel[7:0]<=db_in. With rs=1, reg[regsel]<=db_in&mask | reg&~mask.
- R16/R17 are read-only. R37 is writable only when version[1]=1.
- Bus read = cs&~we&bus_en. With rs=0, db_out<={~busy, lp_status, vsync, overflow, 2'b00, version}; lp_status and overflow clear in the same cycle. With rs=1, db_out<=reg|~mask; R31 returns data_latch.
- Light pen: lp_strobe with lp_status=0 latches R17<=lp_h, R16<=lp_v, lp_status<=1. Further strobes are ignored until lp_status clears. If a strobe and a clearing status read coincide, the clear wins.
- RAM forwarding applies to a data-port write to R18, R19, R30, R31, R32 or R33 (ram_we=1), and to a data-port read of R31 (ram_we=0, ram_reg=31).
  - Idle (no request outstanding): the request is issued next cycle.
  - Outstanding and pending empty: the request is stored in pending.
  - Pending full: the request is dropped and overflow<=1.
- ram_req holds stable with ram_reg/ram_we/ram_wdata until the ram_ack cycle, then drops. If pending is valid, it issues the cycle after ack.
- A read ack loads data_latch<=ram_rdata.
- Reset: all registers 0 except R37=8'hC0 (if NREGS>37). regsel=0, lp_status=0, overflow=0, pending empty, ram_req=0, ram_we=0, ram_reg=0, ram_wdata=0, db_out=0, data_latch=0, busy=0.
- Reset mid-handshake abandons the request; ram_ack arriving with ram_req=0 is ignored.

## Timing
- Bus write in cycle N: regs_q updated at N+1, ram_req high at N+1 if idle.
- Bus read in cycle N: db_out valid at N+1 and held until the next read.
- ram_ack in cycle M: ram_req low at M+1; a pending request asserts at M+2, giving one idle cycle between requests.
- A new access arriving in the ack cycle goes to pending if pending is empty, otherwise it is dropped.
- busy falls the cycle after the final ack.

## Configuration
- VDC_REGBANK_SHADOW_EN defined:
  - Data-port writes to R0–R9 go to a shadow copy, and the data-port read of R0–R9 returns the shadow.
  - regs_q slices for R0–R9 load from the shadow on frame_start.
  - A write coinciding with frame_start commits the new value.
  - Reset clears both copies.
- Undefined: no shadow; R0–R9 take effect at N+1 like every other register.

## Test plan
- Reset, then read status with version=2, vsync=0 -> db_out=8'h82; read regsel 37 -> 8'hC0.
- Write regsel=22, data 8'h5A with WMASK[22]=8'h0F -> regs_q R22=8'h0A; readback 8'hFA.
- lp_strobe with lp_h=8'h40, lp_v=8'h12, then a second strobe with 8'h41 -> R17=8'h40, R16=8'h12; status bit6=1, then 0 on the next status read.
- Writes to R31 of 8'h11, 8'h22, 8'h33 with ram_ack held low -> first issued, second pending, third dropped, overflow=1, busy=1. After two acks, busy=0 and ram_wdata sequence is 11, 22.
- Read R31 with ram_rdata=8'h9C on ack -> the next R31 read returns 8'h9C.
- With VDC_REGBANK_SHADOW_EN, write R0=8'h7E -> regs_q R0 unchanged until the frame_start pulse, =8'h7E the cycle after.

Source files
------------

// File: rtl/vdc_regbank.sv
// vdc_regbank: indirect CPU register bank for the C128 VDC (8563/8568) family.
// Holds NREGS 8-bit registers behind an address/status port and a data port.
// Per-register WMASK bits mark which bits are implemented. Unimplemented bits
// are never stored and read back as 1.
// Also latches the light pen position into R16/R17.
// Accesses to the RAM-side registers (R18/19/30-33, plus a read-ahead on a
// R31 read) are forwarded over a req/ack handshake with one pending slot.
//
// Build option: VDC_REGBANK_SHADOW_EN double-buffers R0-R9, the CRTC timing
// registers, so that new values take effect only on frame_start.
module vdc_regbank #(
    parameter int                 NREGS = 38,
    parameter logic [8*NREGS-1:0] WMASK = {NREGS{8'hFF}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         version,
    input  logic               bus_en,
    input  logic               cs,
    input  logic               rs,
    input  logic               we,
    input  logic [7:0]         db_in,
    output logic [7:0]         db_out,
    input  logic               lp_strobe,
    input  logic [7:0]         lp_h,
    input  logic [7:0]         lp_v,
    input  logic               vsync,
    input  logic               frame_start,
    output logic [8*NREGS-1:0] regs_q,
    output logic               ram_req,
    output logic               ram_we,
    output logic [5:0]         ram_reg,
    output logic [7:0]         ram_wdata,
    input  logic               ram_ack,
    input  logic [7:0]         ram_rdata,
    output logic               busy,
    output logic               overflow
);

    localparam logic [7:0] MASK_R16 = WMASK[8*16 +: 8];
    localparam logic [7:0] MASK_R17 = WMASK[8*17 +: 8];

    logic [7:0] bank_q [NREGS];
    logic [7:0] bank_d [NREGS];
    logic [7:0] regsel_q, regsel_d;
    logic       lp_status_q, lp_status_d;
    logic       overflow_q, overflow_d;
    logic [7:0] data_latch_q, data_latch_d;
    logic [7:0] db_out_q, db_out_d;

    logic       req_q, req_d;
    logic       req_we_q, req_we_d;
    logic [5:0] req_reg_q, req_reg_d;
    logic [7:0] req_wdata_q, req_wdata_d;
    logic       pend_v_q, pend_v_d;
    logic       pend_we_q, pend_we_d;
    logic [5:0] pend_reg_q, pend_reg_d;
    logic [7:0] pend_wdata_q, pend_wdata_d;

`ifdef VDC_REGBANK_SHADOW_EN
    logic [7:0] shadow_q [10];
    logic [7:0] shadow_d [10];
    logic       shadow_hit;
`endif

    logic       bus_wr, bus_rd, status_rd;
    logic [5:0] idx;
    logic       sel_ok, writable, data_wr;
    logic [7:0] mask;
    logic       fwd_wr, fwd_rd, fwd;
    logic [5:0] fwd_reg;
    logic       ack, lp_take;
    logic [7:0] rd_data;

    assign bus_wr    = cs & we & bus_en;
    assign bus_rd    = cs & ~we & bus_en;
    assign status_rd = bus_rd & ~rs;
    assign idx       = regsel_q[5:0];
    assign sel_ok    = (regsel_q < 8'(NREGS));
    assign mask      = WMASK[{idx, 3'b000} +: 8];
    // R16/R17 belong to the light pen; R37 exists only on the 8568.
    assign writable  = sel_ok && (idx != 6'd16) && (idx != 6'd17) &&
                       !((idx == 6'd37) && !version[1]);
    assign data_wr   = bus_wr & rs & writable;

    assign fwd_wr  = bus_wr & rs & ((regsel_q == 8'd18) || (regsel_q == 8'd19) ||
                     ((regsel_q >= 8'd30) && (regsel_q <= 8'd33)));
    assign fwd_rd  = bus_rd & rs & (regsel_q == 8'd31);
    assign fwd     = fwd_wr | fwd_rd;
    assign fwd_reg = fwd_wr ? idx : 6'd31;

    // An ack seen while no request is up (e.g. after reset) is stale.
    assign ack     = ram_ack & req_q;
    // A clearing status read wins over a coincident strobe.
    assign lp_take = lp_strobe & ~lp_status_q & ~status_rd;

`ifdef VDC_REGBANK_SHADOW_EN
    assign shadow_hit = (regsel_q < 8'd10);
`endif

    // Register bank, shadow copy and light pen latch next state.
    always_comb begin
        bank_d      = bank_q;
        lp_status_d = lp_status_q;
`ifdef VDC_REGBANK_SHADOW_EN
        shadow_d    = shadow_q;
`endif
        if (data_wr) begin
`ifdef VDC_REGBANK_SHADOW_EN
            if (shadow_hit) begin
                shadow_d[idx[3:0]] = (db_in & mask) | (shadow_q[idx[3:0]] & ~mask);
            end else begin
                bank_d[idx] = (db_in & mask) | (bank_q[idx] & ~mask);
            end
`else
            bank_d[idx] = (db_in & mask) | (bank_q[idx] & ~mask);
`endif
        end
        if (lp_take) begin
            bank_d[17] = lp_h & MASK_R17;
            bank_d[16] = lp_v & MASK_R16;
        end
`ifdef VDC_REGBANK_SHADOW_EN
        // Commit uses shadow_d so a write in the frame_start cycle lands.
        if (frame_start) begin
            for (int i = 0; i < 10; i++) begin
                bank_d[6'(i)] = shadow_d[4'(i)];
            end
        end
`endif
        if (status_rd) begin
            lp_status_d = 1'b0;
        end else if (lp_take) begin
            lp_status_d = 1'b1;
        end
    end

    // CPU read mux and address register.
    always_comb begin
        rd_data = 8'hFF;
        if (!rs) begin
            rd_data = {~busy, lp_status_q, vsync, overflow_q, 2'b00, version};
        end else if (!sel_ok) begin
            rd_data = 8'hFF;
        end else if (regsel_q == 8'd31) begin
            rd_data = data_latch_q;
`ifdef VDC_REGBANK_SHADOW_EN
        end else if (shadow_hit) begin
            rd_data = shadow_q[idx[3:0]] | ~mask;
`endif
        end else begin
            rd_data = bank_q[idx] | ~mask;
        end
        db_out_d = bus_rd ? rd_data : db_out_q;
        regsel_d = (bus_wr & ~rs) ? db_in : regsel_q;
    end

    // RAM request slot, single pending entry and overflow flag.
    always_comb begin
        req_d        = req_q;
        req_we_d     = req_we_q;
        req_reg_d    = req_reg_q;
        req_wdata_d  = req_wdata_q;
        pend_v_d     = pend_v_q;
        pend_we_d    = pend_we_q;
        pend_reg_d   = pend_reg_q;
        pend_wdata_d = pend_wdata_q;
        overflow_d   = overflow_q;
        data_latch_d = data_latch_q;

        if (ack) begin
            req_d = 1'b0;
            if (!req_we_q) begin
                data_latch_d = ram_rdata;
            end
        end else if (!req_q && pend_v_q) begin
            // One idle cycle after an ack, then the pending entry goes out.
            req_d       = 1'b1;
            req_we_d    = pend_we_q;
            req_reg_d   = pend_reg_q;
            req_wdata_d = pend_wdata_q;
            pend_v_d    = 1'b0;
        end

        if (fwd) begin
            if (!req_q && !pend_v_q) begin
                req_d       = 1'b1;
                req_we_d    = fwd_wr;
                req_reg_d   = fwd_reg;
                req_wdata_d = db_in;
            end else if (!pend_v_q) begin
                pend_v_d     = 1'b1;
                pend_we_d    = fwd_wr;
                pend_reg_d   = fwd_reg;
                pend_wdata_d = db_in;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (status_rd) begin
            overflow_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                bank_q[6'(r)] <= (r == 37) ? 8'hC0 : 8'h00;
            end
`ifdef VDC_REGBANK_SHADOW_EN
            for (int i = 0; i < 10; i++) begin
                shadow_q[4'(i)] <= 8'h00;
            end
`endif
            regsel_q     <= 8'h00;
            lp_status_q  <= 1'b0;
            overflow_q   <= 1'b0;
            data_latch_q <= 8'h00;
            db_out_q     <= 8'h00;
            req_q        <= 1'b0;
            req_we_q     <= 1'b0;
            req_reg_q    <= 6'd0;
            req_wdata_q  <= 8'h00;
            pend_v_q     <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_reg_q   <= 6'd0;
            pend_wdata_q <= 8'h00;
        end else begin
            bank_q       <= bank_d;
`ifdef VDC_REGBANK_SHADOW_EN
            shadow_q     <= shadow_d;
`endif
            regsel_q     <= regsel_d;
            lp_status_q  <= lp_status_d;
            overflow_q   <= overflow_d;
            data_latch_q <= data_latch_d;
            db_out_q     <= db_out_d;
            req_q        <= req_d;
            req_we_q     <= req_we_d;
            req_reg_q    <= req_reg_d;
            req_wdata_q  <= req_wdata_d;
            pend_v_q     <= pend_v_d;
            pend_we_q    <= pend_we_d;
            pend_reg_q   <= pend_reg_d;
            pend_wdata_q <= pend_wdata_d;
        end
    end

    // Flatten the bank onto the effective-value output bus.
    always_comb begin
        regs_q = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_q[8*i +: 8] = bank_q[6'(i)];
        end
    end

    assign db_out    = db_out_q;
    assign ram_req   = req_q;
    assign ram_we    = req_we_q;
    assign ram_reg   = req_reg_q;
    assign ram_wdata = req_wdata_q;
    assign busy      = req_q | pend_v_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_vdc_regbank.sv
`timescale 1ns/1ps
module tb_vdc_regbank;
    localparam int NR = 38;
    // R22 implements only its low nibble; everything else is fully implemented.
    localparam logic [8*NR-1:0] WM = {{15{8'hFF}}, 8'h0F, {22{8'hFF}}};

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    version;
    logic          bus_en, cs, rs, we;
    logic [7:0]    db_in, db_out;
    logic          lp_strobe;
    logic [7:0]    lp_h, lp_v;
    logic          vsync, frame_start;
    logic [8*NR-1:0] regs_q;
    logic          ram_req, ram_we;
    logic [5:0]    ram_reg;
    logic [7:0]    ram_wdata;
    logic          ram_ack;
    logic [7:0]    ram_rdata;
    logic          busy, overflow;

    always #5 clk = ~clk;

    vdc_regbank #(.NREGS(NR), .WMASK(WM)) dut (
        .clk(clk), .reset(reset), .version(version), .bus_en(bus_en),
        .cs(cs), .rs(rs), .we(we), .db_in(db_in), .db_out(db_out),
        .lp_strobe(lp_strobe), .lp_h(lp_h), .lp_v(lp_v), .vsync(vsync),
        .frame_start(frame_start), .regs_q(regs_q), .ram_req(ram_req),
        .ram_we(ram_we), .ram_reg(ram_reg), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .ram_rdata(ram_rdata), .busy(busy),
        .overflow(overflow)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       we;
        logic [5:0] rg;
        logic [7:0] wd;
    } rq_t;

    rq_t        mq[$];      // front = request on the wire (unless in gap)
    bit         m_gap;      // the one dead cycle after an ack
    logic [7:0] m_regs[NR];
    logic [7:0] m_shadow[10];
    logic [7:0] m_sel, m_latch, m_db;
    logic       m_lp, m_ovf;

    function automatic logic [7:0] mk(input int r);
        return WM[8*r +: 8];
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = (i == 37) ? 8'hC0 : 8'h00;
        for (int i = 0; i < 10; i++) m_shadow[i] = 8'h00;
        m_sel = 0; m_latch = 0; m_db = 0; m_lp = 0; m_ovf = 0;
        mq.delete(); m_gap = 0;
    endfunction

    initial m_reset();

    always @(posedge clk) begin
        bit   brd, bwr, clr, fwd, ack, full, sh;
        rq_t  nr;
        if (reset) begin
            m_reset();
        end else begin
            brd = cs && !we && bus_en;
            bwr = cs && we && bus_en;
            ack = ram_ack && !m_gap && (mq.size() > 0);
            clr = 0; fwd = 0;
            sh = 0;
`ifdef VDC_REGBANK_SHADOW_EN
            sh = (m_sel < 10);
`endif
            if (brd) begin
                if (!rs) begin
                    m_db = {(mq.size() == 0), m_lp, vsync, m_ovf, 2'b00, version};
                    clr = 1;
                end else if (m_sel >= NR) m_db = 8'hFF;
                else if (m_sel == 31) m_db = m_latch;
                else if (sh) m_db = m_shadow[m_sel] | ~mk(m_sel);
                else m_db = m_regs[m_sel] | ~mk(m_sel);
                if (rs && m_sel == 31) begin fwd = 1; nr = '{1'b0, 6'd31, db_in}; end
            end
            if (bwr) begin
                if (!rs) m_sel = db_in;
                else begin
                    if (m_sel < NR && m_sel != 16 && m_sel != 17 && !(m_sel == 37 && !version[1])) begin
                        if (sh) m_shadow[m_sel] = (db_in & mk(m_sel)) | (m_shadow[m_sel] & ~mk(m_sel));
                        else m_regs[m_sel] = (db_in & mk(m_sel)) | (m_regs[m_sel] & ~mk(m_sel));
                    end
                    if (m_sel inside {18, 19, 30, 31, 32, 33}) begin
                        fwd = 1; nr = '{1'b1, m_sel[5:0], db_in};
                    end
                end
            end
            if (lp_strobe && !m_lp && !clr) begin
                m_regs[17] = lp_h & mk(17);
                m_regs[16] = lp_v & mk(16);
                m_lp = 1;
            end
`ifdef VDC_REGBANK_SHADOW_EN
            if (frame_start) for (int i = 0; i < 10; i++) m_regs[i] = m_shadow[i];
`endif
            if (clr) begin m_lp = 0; m_ovf = 0; end
            if (fwd) begin
                // in the gap the queued entry is the pending one
                full = m_gap ? (mq.size() >= 1) : (mq.size() >= 2);
                if (full) m_ovf = 1;
                else mq.push_back(nr);
            end
            if (ack) begin
                if (!mq[0].we) m_latch = ram_rdata;
                void'(mq.pop_front());
                m_gap = 1;
            end else m_gap = 0;
        end
    end

    // compare process: outputs are registered, so sample mid-cycle
    always @(negedge clk) begin
        logic [8*NR-1:0] flat;
        bit exp_req;
        for (int i = 0; i < NR; i++) flat[8*i +: 8] = m_regs[i];
        exp_req = !m_gap && (mq.size() > 0);
        chk("regs_q", regs_q, flat);
        chk("db_out", db_out, m_db);
        chk("busy", busy, mq.size() > 0);
        chk("overflow", overflow, m_ovf);
        chk("ram_req", ram_req, exp_req);
        if (exp_req) begin
            chk("ram_we", ram_we, mq[0].we);
            chk("ram_reg", ram_reg, mq[0].rg);
            if (mq[0].we) chk("ram_wdata", ram_wdata, mq[0].wd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic w, input logic [7:0] d);
        cs = 1; rs = r; we = w; db_in = d; bus_en = 1;
        step();
        cs = 0; we = 0;
    endtask

    task automatic wait_req(input string nm);
        int k = 0;
        while (!ram_req && k < 10) begin step(); k++; end
        chk(nm, ram_req, 1'b1);
    endtask

    initial begin
        reset = 1; version = 2'd2; bus_en = 0; cs = 0; rs = 0; we = 0; db_in = 0;
        lp_strobe = 0; lp_h = 0; lp_v = 0; vsync = 0; frame_start = 0;
        ram_ack = 0; ram_rdata = 0;
        step(); step();
        reset = 0;
        step();

        bus(0, 0, 0);
        chk("status_after_reset", db_out, 8'h82);
        bus(0, 1, 8'd37);
        bus(1, 0, 0);
        chk("r37_reset", db_out, 8'hC0);

        bus(0, 1, 8'd22);
        bus(1, 1, 8'h5A);
        chk("r22_masked", regs_q[22*8 +: 8], 8'h0A);
        bus(1, 0, 0);
        chk("r22_readback", db_out, 8'hFA);

        lp_h = 8'h40; lp_v = 8'h12; lp_strobe = 1; step();
        lp_strobe = 0; step();
        lp_h = 8'h41; lp_v = 8'h13; lp_strobe = 1; step();
        lp_strobe = 0;
        chk("lp_r17", regs_q[17*8 +: 8], 8'h40);
        chk("lp_r16", regs_q[16*8 +: 8], 8'h12);
        bus(0, 0, 0);
        chk("lp_status_set", db_out[6], 1'b1);
        bus(0, 0, 0);
        chk("lp_status_clr", db_out[6], 1'b0);

        bus(0, 1, 8'd31);
        bus(1, 1, 8'h11);
        bus(1, 1, 8'h22);
        bus(1, 1, 8'h33);
        chk("ram_first_wdata", ram_wdata, 8'h11);
        chk("ram_overflow", overflow, 1'b1);
        chk("ram_busy", busy, 1'b1);
        ram_ack = 1; step(); ram_ack = 0;
        chk("ram_gap_req", ram_req, 1'b0);
        chk("ram_gap_busy", busy, 1'b1);
        step();
        chk("ram_second_req", ram_req, 1'b1);
        chk("ram_second_wdata", ram_wdata, 8'h22);
        ram_ack = 1; step(); ram_ack = 0;
        chk("ram_idle_busy", busy, 1'b0);
        bus(0, 0, 0);
        chk("status_ovf", db_out, 8'h92);

        bus(1, 0, 0);
        wait_req("rd_req");
        chk("rd_req_we", ram_we, 1'b0);
        ram_rdata = 8'h9C; ram_ack = 1; step(); ram_ack = 0; ram_rdata = 0;
        bus(1, 0, 0);
        chk("r31_latch", db_out, 8'h9C);
        wait_req("rd_req2");
        ram_ack = 1; step(); ram_ack = 0;
        step();

`ifdef VDC_REGBANK_SHADOW_EN
        bus(0, 1, 8'd0);
        bus(1, 1, 8'h7E);
        step();
        chk("shadow_hold", regs_q[7:0], 8'h00);
        frame_start = 1; step(); frame_start = 0;
        chk("shadow_commit", regs_q[7:0], 8'h7E);
`endif

        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 799) == 0);
            bus_en = ($urandom_range(0, 9) != 0);
            cs     = ($urandom_range(0, 9) < 4);
            we     = 1'($urandom_range(0, 1));
            rs     = ($urandom_range(0, 3) != 0);
            if (!rs && we)
                db_in = ($urandom_range(0, 2) == 0) ? 8'd31 : 8'($urandom_range(0, 47));
            else
                db_in = 8'($urandom);
            lp_strobe   = ($urandom_range(0, 9) == 0);
            lp_h        = 8'($urandom);
            lp_v        = 8'($urandom);
            vsync       = 1'($urandom_range(0, 1));
            frame_start = ($urandom_range(0, 19) == 0);
            ram_ack     = ($urandom_range(0, 2) == 0);
            ram_rdata   = 8'($urandom);
            if (c % 256 == 0) version = 2'($urandom);
            step();
        end
        reset = 0; cs = 0; we = 0; lp_strobe = 0; frame_start = 0; ram_ack = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
